// File: rtl/decoder_pkg.sv
// Shared widths and the reference one-hot decode function
// for the registered 2-to-4 decoder.
package decoder_pkg;

    localparam int DEC_IN_W  = 2;
    localparam int DEC_OUT_W = 4;

    // Active-high one-hot decode; any code containing X/Z
    // falls through to the default and decodes to all zeros.
    function automatic logic [DEC_OUT_W-1:0] onehot_dec(
        input logic [DEC_IN_W-1:0] code
    );
        logic [DEC_OUT_W-1:0] r;
        case (code)
            2'b00:   r = 4'b0001;
            2'b01:   r = 4'b0010;
            2'b10:   r = 4'b0100;
            2'b11:   r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decoder2to4_comb.sv
// Combinational 2-to-4 one-hot decode core.
// Ports: i_code (2-bit select) -> o_onehot (4-bit, active-high).
module decoder2to4_comb
    import decoder_pkg::*;
(
    input  logic [DEC_IN_W-1:0]  i_code,
    output logic [DEC_OUT_W-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        case (i_code)
            2'b00:   o_onehot = 4'b0001;
            2'b01:   o_onehot = 4'b0010;
            2'b10:   o_onehot = 4'b0100;
            2'b11:   o_onehot = 4'b1000;
            default: o_onehot = '0;
        endcase
    end

endmodule

// File: rtl/decoder_2to4_beh.sv
// Registered 2-to-4 one-hot decoder with enable, valid
// qualification and code-change pulse.
// Ports: clk, rst (async, active-high), en, in[1:0] ->
//   out[3:0] (one-hot, optionally active-low), out_valid,
//   code_change (previous valid code differed).
module decoder_2to4_beh
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DEC_IN_W-1:0]  in,
    output logic [DEC_OUT_W-1:0] out,
    output logic                 out_valid,
    output logic                 code_change
);

    // XOR mask doubles as the "all deasserted" pattern.
    localparam logic [DEC_OUT_W-1:0] OFF_PAT =
        {DEC_OUT_W{OUT_ACTIVE_LOW}};

    logic [DEC_OUT_W-1:0] w_onehot;
    logic [DEC_OUT_W-1:0] r_out;
    logic                 r_valid;
    logic                 r_chg;
    logic [DEC_IN_W-1:0]  r_prev;
    logic                 r_prev_vld;

    decoder2to4_comb u_core (
        .i_code   (in),
        .o_onehot (w_onehot)
    );

    // Previous code survives en=0 gaps so change detection
    // compares against the last enabled sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out      <= OFF_PAT;
            r_valid    <= 1'b0;
            r_chg      <= 1'b0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (en) begin
            r_out      <= w_onehot ^ OFF_PAT;
            r_valid    <= 1'b1;
            r_chg      <= r_prev_vld && (in != r_prev);
            r_prev     <= in;
            r_prev_vld <= 1'b1;
        end else begin
            r_out      <= OFF_PAT;
            r_valid    <= 1'b0;
            r_chg      <= 1'b0;
        end
    end

    assign out         = r_out;
    assign out_valid   = r_valid;
    assign code_change = r_chg;

endmodule

// File: tb/tb_decoder_2to4_beh.sv
// Self-checking bench for decoder_2to4_beh: both polarities
// driven in parallel against a behavioural model.
module tb_decoder_2to4_beh;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] sel = 2'b00;

    logic [3:0] out_hi, out_lo;
    logic       vld_hi, vld_lo, chg_hi, chg_lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [1:0] m_prev;
    bit         m_prev_vld;
    logic [3:0] m_out;
    bit         m_vld;
    bit         m_chg;

    always #5 clk = ~clk;

    decoder_2to4_beh #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .en(en), .in(sel),
        .out(out_hi), .out_valid(vld_hi),
        .code_change(chg_hi)
    );

    decoder_2to4_beh #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .en(en), .in(sel),
        .out(out_lo), .out_valid(vld_lo),
        .code_change(chg_lo)
    );

    task automatic model_reset();
        m_prev     = 2'b00;
        m_prev_vld = 0;
        m_out      = 4'b0000;
        m_vld      = 0;
        m_chg      = 0;
    endtask

    // Apply one sample, clock it, update the model, and
    // leave time 1 unit after the edge for sampling.
    task automatic drive(input bit e, input logic [1:0] c);
        en  = e;
        sel = c;
        @(posedge clk);
        #1;
        m_vld = e;
        m_chg = e && m_prev_vld && (c != m_prev);
        m_out = e ? (4'b0001 << c) : 4'b0000;
        if (e) begin
            m_prev     = c;
            m_prev_vld = 1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({out_hi, out_lo} !== 8'b0000_1111) begin
            n_bad++;
            $display("FAIL reset_out hi/lo=%b/%b want 0000/1111",
                     out_hi, out_lo);
        end
        n_cmp++;
        if ({vld_hi, chg_hi, vld_lo, chg_lo} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000",
                     {vld_hi, chg_hi, vld_lo, chg_lo});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [3:0] want [4];
        bit         wchg [4];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        wchg = '{0, 1, 1, 1};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k));
            n_cmp++;
            if ({out_hi, vld_hi, chg_hi} !==
                {want[k], 1'b1, wchg[k]}) begin
                n_bad++;
                $display("FAIL sweep%0d got %b/%b/%b want %b/1/%b",
                         k, out_hi, vld_hi, chg_hi,
                         want[k], wchg[k]);
            end
            n_cmp++;
            if ({out_lo, vld_lo, chg_lo} !==
                {~want[k], 1'b1, wchg[k]}) begin
                n_bad++;
                $display("FAIL sweep_lo%0d got %b/%b/%b want %b",
                         k, out_lo, vld_lo, chg_lo, ~want[k]);
            end
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b10);
            n_cmp++;
            if ({out_hi, vld_hi, chg_hi} !==
                {4'b0100, 1'b1, (k == 0)}) begin
                n_bad++;
                $display("FAIL hold%0d got %b/%b/%b want 0100/1/%b",
                         k, out_hi, vld_hi, chg_hi, (k == 0));
            end
        end
    endtask

    task automatic test_enable_gap();
        drive(1'b0, 2'b11);
        n_cmp++;
        if ({out_hi, out_lo, vld_hi, chg_hi} !==
            {8'b0000_1111, 2'b00}) begin
            n_bad++;
            $display("FAIL gap_off got %b/%b/%b/%b want 0000/1111/0/0",
                     out_hi, out_lo, vld_hi, chg_hi);
        end
        drive(1'b1, 2'b11);
        n_cmp++;
        if ({out_hi, vld_hi, chg_hi} !== {4'b1000, 2'b11}) begin
            n_bad++;
            $display("FAIL gap_on got %b/%b/%b want 1000/1/1",
                     out_hi, vld_hi, chg_hi);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'b01);
        n_cmp++;
        if (out_hi !== 4'b0010) begin
            n_bad++;
            $display("FAIL areset_pre got %b want 0010", out_hi);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({out_hi, out_lo, vld_hi, vld_lo} !==
            {8'b0000_1111, 2'b00}) begin
            n_bad++;
            $display("FAIL areset_now got %b/%b/%b want 0000/1111/0",
                     out_hi, out_lo, vld_hi);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'b01);
        n_cmp++;
        if ({out_hi, out_lo, vld_hi, chg_hi} !==
            {8'b0010_1101, 2'b10}) begin
            n_bad++;
            $display("FAIL areset_first got %b/%b/%b/%b want 0010/1101/1/0",
                     out_hi, out_lo, vld_hi, chg_hi);
        end
        drive(1'b0, 2'b01);
        n_cmp++;
        if (out_lo !== 4'b1111) begin
            n_bad++;
            $display("FAIL lo_off got %b want 1111", out_lo);
        end
    endtask

    task automatic test_random();
        bit         e;
        logic [1:0] c;
        for (int i = 0; i < 1000; i++) begin
            e = ($urandom_range(0, 3) != 0);
            c = 2'($urandom_range(0, 3));
            drive(e, c);
            n_cmp++;
            if ({out_hi, vld_hi, chg_hi} !==
                {m_out, m_vld, m_chg}) begin
                n_bad++;
                $display("FAIL rand%0d hi got %b/%b/%b want %b/%b/%b",
                         i, out_hi, vld_hi, chg_hi,
                         m_out, m_vld, m_chg);
            end
            n_cmp++;
            if ({out_lo, vld_lo, chg_lo} !==
                {~m_out, m_vld, m_chg}) begin
                n_bad++;
                $display("FAIL rand%0d lo got %b/%b/%b want %b/%b/%b",
                         i, out_lo, vld_lo, chg_lo,
                         ~m_out, m_vld, m_chg);
            end
            n_cmp++;
            if ($countones(out_hi) != (vld_hi ? 1 : 0)) begin
                n_bad++;
                $display("FAIL onehot%0d out=%b valid=%b",
                         i, out_hi, vld_hi);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sweep();
        test_hold();
        test_enable_gap();
        test_async_reset();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
